// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Y86 pipeline-stage register with valid bit, stall/bubble
//                control, hazard statistics and a stall watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned      WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W      = 16,
    parameter int unsigned      MAX_STALL  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             bubble,
    input  logic             clr_stats,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             err_conflict,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_HELD  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_MAX_STALL = CNT_W'(MAX_STALL);

    state_t           state_q,         state_d;
    logic [WIDTH-1:0] out_q,           out_d;
    logic             out_valid_q,     out_valid_d;
    logic [CNT_W-1:0] stall_cnt_q,     stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q,    bubble_cnt_d;
    logic [CNT_W-1:0] run_cnt_q,       run_cnt_d;
    logic             err_conflict_q,  err_conflict_d;
    logic             stall_timeout_q, stall_timeout_d;

    logic w_conflict;
    logic w_bubble_only;

    // A conflict is treated as a stall everywhere except for the sticky flag.
    assign w_conflict    = stall & bubble;
    assign w_bubble_only = bubble & ~stall;

    // Data path and state machine
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (stall) begin
            case (state_q)
                ST_FULL, ST_HELD: state_d = ST_HELD;
                default:          state_d = ST_EMPTY;
            endcase
        end else if (bubble) begin
            out_d       = BUBBLE_VAL;
            out_valid_d = 1'b0;
            state_d     = ST_EMPTY;
        end else begin
            out_d       = in;
            out_valid_d = in_valid;
            state_d     = in_valid ? ST_FULL : ST_EMPTY;
        end
    end

    // Statistics and watchdog
    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        bubble_cnt_d   = bubble_cnt_q;
        err_conflict_d = err_conflict_q | w_conflict;
        run_cnt_d      = '0;

        if (stall && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (w_bubble_only && (bubble_cnt_q != C_CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
        if (clr_stats) begin
            stall_cnt_d    = '0;
            bubble_cnt_d   = '0;
            err_conflict_d = 1'b0;
        end

        if (stall) begin
            run_cnt_d = (run_cnt_q == C_CNT_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
        end
        stall_timeout_d = (run_cnt_d >= C_MAX_STALL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_EMPTY;
            out_q           <= BUBBLE_VAL;
            out_valid_q     <= 1'b0;
            stall_cnt_q     <= '0;
            bubble_cnt_q    <= '0;
            run_cnt_q       <= '0;
            err_conflict_q  <= 1'b0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            out_q           <= out_d;
            out_valid_q     <= out_valid_d;
            stall_cnt_q     <= stall_cnt_d;
            bubble_cnt_q    <= bubble_cnt_d;
            run_cnt_q       <= run_cnt_d;
            err_conflict_q  <= err_conflict_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign out           = out_q;
    assign out_valid     = out_valid_q;
    assign state         = state_q;
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign err_conflict  = err_conflict_q;
    assign stall_timeout = stall_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Randomised self-checking bench for pipe_stage_reg against a
//                cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int unsigned      C_W   = 16;
    localparam logic [C_W-1:0]   C_BV  = 16'h1B1B;
    localparam int unsigned      C_CW  = 3;
    localparam int unsigned      C_MS  = 3;
    localparam int               C_SAT = (1 << C_CW) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [C_W-1:0]   in = '0;
    logic             in_valid = 1'b0;
    logic             stall = 1'b0;
    logic             bubble = 1'b0;
    logic             clr_stats = 1'b0;
    logic [C_W-1:0]   out;
    logic             out_valid;
    logic [1:0]       state;
    logic [C_CW-1:0]  stall_cnt;
    logic [C_CW-1:0]  bubble_cnt;
    logic             err_conflict;
    logic             stall_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integers, saturation by min()
    logic [C_W-1:0] m_out;
    logic           m_valid;
    int             m_state;
    int             m_scnt;
    int             m_bcnt;
    logic           m_err;
    int             m_run;
    logic           m_to;

    pipe_stage_reg #(
        .WIDTH      (C_W),
        .BUBBLE_VAL (C_BV),
        .CNT_W      (C_CW),
        .MAX_STALL  (C_MS)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .in            (in),
        .in_valid      (in_valid),
        .stall         (stall),
        .bubble        (bubble),
        .clr_stats     (clr_stats),
        .out           (out),
        .out_valid     (out_valid),
        .state         (state),
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt),
        .err_conflict  (err_conflict),
        .stall_timeout (stall_timeout)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v + 1 > C_SAT) ? C_SAT : v + 1;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_out = C_BV; m_valid = 1'b0; m_state = 0;
            m_scnt = 0; m_bcnt = 0; m_err = 1'b0; m_run = 0; m_to = 1'b0;
        end else begin
            if (stall) begin
                m_state = (m_state == 1 || m_state == 2) ? 2 : 0;
                m_scnt  = sat_inc(m_scnt);
                m_run   = sat_inc(m_run);
                if (bubble) m_err = 1'b1;
            end else begin
                m_run = 0;
                if (bubble) begin
                    m_out = C_BV; m_valid = 1'b0; m_state = 0;
                    m_bcnt = sat_inc(m_bcnt);
                end else begin
                    m_out = in; m_valid = in_valid; m_state = in_valid ? 1 : 0;
                end
            end
            if (clr_stats) begin
                m_scnt = 0; m_bcnt = 0; m_err = 1'b0;
            end
            m_to = (m_run >= C_MS);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic bb, input logic cl,
                        input logic iv, input logic [C_W-1:0] d);
        reset = r; stall = st; bubble = bb; clr_stats = cl; in_valid = iv; in = d;
        @(posedge clock);
        model_update();
        #1;
        check_val("out",        64'(out),           64'(m_out));
        check_val("out_valid",  64'(out_valid),     64'(m_valid));
        check_val("state",      64'(state),         64'(m_state));
        check_val("stall_cnt",  64'(stall_cnt),     64'(m_scnt));
        check_val("bubble_cnt", 64'(bubble_cnt),    64'(m_bcnt));
        check_val("err",        64'(err_conflict),  64'(m_err));
        check_val("timeout",    64'(stall_timeout), 64'(m_to));
    endtask

    initial begin
        logic [C_W-1:0] rnd;
        int             mode;
        int             exp_to [4];
        exp_to = '{0, 0, 1, 1};

        // Reset then load
        step(1, 0, 0, 0, 0, 16'hFFFF);
        check_val("rst_out", 64'(out), 64'(C_BV));
        check_val("rst_state", 64'(state), 64'd0);
        step(0, 0, 0, 0, 1, 16'h1234);
        check_val("load_out", 64'(out), 64'h1234);
        check_val("load_state", 64'(state), 64'd1);

        // Stall hold with watchdog
        step(0, 0, 0, 0, 1, 16'h00AA);
        for (int k = 0; k < 4; k++) begin
            rnd = 16'($urandom);
            step(0, 1, 0, 0, 1, rnd);
            check_val("hold_out", 64'(out), 64'h00AA);
            check_val("hold_state", 64'(state), 64'd2);
            check_val("hold_to", 64'(stall_timeout), 64'(exp_to[k]));
        end
        step(0, 0, 0, 0, 1, 16'h0077);
        check_val("release_to", 64'(stall_timeout), 64'd0);
        check_val("release_out", 64'(out), 64'h0077);

        // Bubble
        step(0, 0, 0, 0, 1, 16'h0007);
        step(0, 0, 1, 0, 1, 16'h0009);
        check_val("bub_out", 64'(out), 64'(C_BV));
        check_val("bub_valid", 64'(out_valid), 64'd0);

        // Conflict, sticky error, then clear while holding
        step(0, 0, 0, 0, 1, 16'h0055);
        step(0, 1, 1, 0, 1, 16'h0066);
        check_val("conf_out", 64'(out), 64'h0055);
        check_val("conf_err", 64'(err_conflict), 64'd1);
        step(0, 0, 0, 0, 0, 16'h0000);
        check_val("err_sticky", 64'(err_conflict), 64'd1);
        step(0, 0, 0, 0, 1, 16'h0055);
        step(0, 1, 0, 1, 1, 16'h0099);
        check_val("clr_err", 64'(err_conflict), 64'd0);
        check_val("clr_out", 64'(out), 64'h0055);

        // Saturation
        for (int k = 0; k < 9; k++) step(0, 0, 1, 0, 0, 16'($urandom));
        check_val("bub_sat", 64'(bubble_cnt), 64'(C_SAT));
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0, 16'($urandom));
        check_val("stall_sat", 64'(stall_cnt), 64'(C_SAT));
        check_val("sat_to", 64'(stall_timeout), 64'd1);

        // Reset mid-stall
        step(0, 0, 0, 0, 1, 16'h0101);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 1, 16'($urandom));
        step(1, 1, 0, 0, 1, 16'($urandom));
        check_val("mid_rst_to", 64'(stall_timeout), 64'd0);
        check_val("mid_rst_out", 64'(out), 64'(C_BV));
        step(0, 1, 0, 0, 1, 16'($urandom));
        check_val("post_rst_scnt", 64'(stall_cnt), 64'd1);
        step(0, 1, 0, 0, 1, 16'($urandom));
        check_val("post_rst_to2", 64'(stall_timeout), 64'd0);
        step(0, 1, 0, 0, 1, 16'($urandom));
        check_val("post_rst_to3", 64'(stall_timeout), 64'd1);

        // Random traffic, alternating between normal and stall-heavy phases
        mode = 0;
        for (int n = 0; n < 3000; n++) begin
            if ((n % 24) == 0) mode = int'($urandom_range(0, 2));
            step($urandom_range(0, 99) < 2,
                 (mode == 2) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 25),
                 (mode == 1) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 20),
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 70,
                 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
